alu_share_arbiter: RTL

//  Shares one ALU datapath between two requesters (req0: core execute path, req1: address/branch helper).

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core.sv | 25 ++
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: ALU control codes and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: ADD/SUB wrap modulo 2^WIDTH, AND/OR bitwise, unknown codes yield zero.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);

    // Operation decode; carries and overflow are intentionally dropped.
    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter around one shared ALU with LATENCY-cycle execute and valid/ready response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins ties); default is round-robin.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero
);

    localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    alu_state_e       state_r;
    alu_state_e       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic             grant_id_s;
    logic [3:0]       cap_ctrl_r;
    logic [WIDTH-1:0] cap_a_r;
    logic [WIDTH-1:0] cap_b_r;
    logic             cap_id_r;
    logic [WIDTH-1:0] alu_result_s;
    logic             resp_valid_r;
    logic             resp_id_r;
    logic [WIDTH-1:0] resp_data_r;
    logic             resp_zero_r;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_grant_r;
`endif

    // Grant selection among pending requesters.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant0_s = req0_valid;
        grant1_s = req1_valid & ~req0_valid;
`else
        if (req0_valid && req1_valid) begin
            grant0_s = last_grant_r;
            grant1_s = ~last_grant_r;
        end else begin
            grant0_s = req0_valid;
            grant1_s = req1_valid;
        end
`endif
    end

    // Readys are forced low while reset is held, not just after the state clears.
    assign req0_ready = reset_n & (state_r == IDLE) & grant0_s;
    assign req1_ready = reset_n & (state_r == IDLE) & grant1_s;
    assign accept_s   = req0_ready | req1_ready;
    assign grant_id_s = ~req0_ready;

    // Next-state decode for IDLE -> EXEC -> RESP -> IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = EXEC;
                else          state_nxt_s = IDLE;
            end
            EXEC: begin
                if (cnt_r == '0) state_nxt_s = RESP;
                else             state_nxt_s = EXEC;
            end
            RESP: begin
                if (resp_ready) state_nxt_s = IDLE;
                else            state_nxt_s = RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_nxt_s;
    end

    // Operand capture at accept; later requester changes cannot reach the ALU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_ctrl_r <= 4'b0000;
            cap_a_r    <= '0;
            cap_b_r    <= '0;
            cap_id_r   <= 1'b0;
        end else if (accept_s) begin
            cap_ctrl_r <= req0_ready ? req0_ctrl : req1_ctrl;
            cap_a_r    <= req0_ready ? req0_a    : req1_a;
            cap_b_r    <= req0_ready ? req0_b    : req1_b;
            cap_id_r   <= grant_id_s;
        end
    end

    // Execute-phase down-counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                cnt_r <= '0;
        else if (accept_s)                           cnt_r <= CNT_LOAD;
        else if ((state_r == EXEC) && (cnt_r != '0)) cnt_r <= cnt_r - CNT_W'(1);
        else                                         cnt_r <= cnt_r;
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin history; resets to 1 so req0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      last_grant_r <= 1'b1;
        else if (accept_s) last_grant_r <= grant_id_s;
        else               last_grant_r <= last_grant_r;
    end
`endif

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .ctrl   (cap_ctrl_r),
        .a      (cap_a_r),
        .b      (cap_b_r),
        .result (alu_result_s)
    );

    // Response registers: loaded at the end of EXEC, held until the consumer takes them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_data_r  <= '0;
            resp_zero_r  <= 1'b0;
        end else if ((state_r == EXEC) && (cnt_r == '0)) begin
            resp_valid_r <= 1'b1;
            resp_id_r    <= cap_id_r;
            resp_data_r  <= alu_result_s;
            resp_zero_r  <= (alu_result_s == '0);
        end else if ((state_r == RESP) && resp_ready) begin
            resp_valid_r <= 1'b0;
        end else begin
            resp_valid_r <= resp_valid_r;
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;
    assign resp_zero  = resp_zero_r;

endmodule
